// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// Module: pipe_stage_reg
//
// Purpose
//    Generic inter-stage register for the 5-stage RISC-V pipeline. It replaces
//    the per-struct IF/ID, ID/EX, EX/MEM and MEM/WB flops with one block. The
//    payload is any packed stage struct of DATA_W bits.
//
//    The block provides:
//       - a valid/ready handshake on both sides
//       - a synchronous flush that inserts a bubble
//       - an occupancy output
//       - a saturating counter of downstream stall cycles
//
// Configuration
//    PIPE_SKID_EN  When defined, the block is built as a 2-entry skid buffer
//                  (main register plus skid register). in_ready then depends
//                  only on flush and the skid register, so there is no
//                  combinational path from out_ready to in_ready.
//                  When undefined, the block is a single register, and in_ready
//                  follows out_ready combinationally.
//
// Parameters
//    DATA_W       payload width in bits (default is the IF/ID struct: 32+9+9)
//    RESET_VAL    payload value after reset or flush (bubble/NOP encoding)
//    STALL_CNT_W  width of the stall performance counter
//
// Ports
//    clk            rising-edge clock
//    rst_n          asynchronous active-low reset
//    flush          synchronous flush; discards every held entry
//    in_valid       upstream payload valid
//    in_ready       stage can accept this cycle
//    in_data        upstream payload
//    out_valid      payload valid to downstream
//    out_ready      downstream accepts this cycle
//    out_data       payload to downstream
//    occupancy      number of entries held (0..1, or 0..2 with the skid buffer)
//    stall_cnt_clr  synchronous clear of stall_cnt
//    stall_cnt      number of cycles with out_valid && !out_ready (saturating)
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int unsigned             DATA_W      = 50,
   parameter logic [DATA_W-1:0]       RESET_VAL   = '0,
   parameter int unsigned             STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_W-1:0]      in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic [1:0]             occupancy,
   input  logic                   stall_cnt_clr,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   // The main register always feeds the downstream side, in both build
   // variants. The skid register, when present, only queues the item behind it.
   logic              main_valid;
   logic [DATA_W-1:0] main_data;

   // One transfer on each side of the stage during the current cycle.
   logic accept;
   logic deliver;

   assign out_valid = main_valid;
   assign out_data  = main_data;

   assign accept  = in_valid && in_ready;
   assign deliver = main_valid && out_ready;

`ifdef PIPE_SKID_EN

   logic              skid_valid;
   logic [DATA_W-1:0] skid_data;

   // in_ready depends only on flush and on state. An item can be taken
   // whenever the skid slot is free: if the main register turns out to be
   // stalled, the item is parked in the skid slot. That lets the upstream
   // stage decide without looking at out_ready.
   assign in_ready = !flush && !skid_valid;

   // Occupancy is the count of valid entries. Because it is taken straight
   // from the valid flops, it changes on the same edge as they do.
   assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

   // Two-entry storage update.
   //
   // Flush wins over everything else and returns both slots to the bubble
   // value. An item delivered in the flush cycle has already been seen
   // downstream, so it needs no special handling.
   //
   // Otherwise:
   //    - When the skid slot is full, the only legal move is to promote the
   //      skid entry into main once main drains. in_ready is low in that
   //      state, so nothing new can arrive in the same cycle.
   //    - When the skid slot is empty, a new item goes into main if main is
   //      free or draining this cycle. If main is stalled, the new item goes
   //      into skid.
   //
   // This keeps FIFO order: skid is only ever filled behind a live main entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid <= 1'b0;
         main_data  <= RESET_VAL;
         skid_valid <= 1'b0;
         skid_data  <= RESET_VAL;
      end else if (flush) begin
         main_valid <= 1'b0;
         main_data  <= RESET_VAL;
         skid_valid <= 1'b0;
         skid_data  <= RESET_VAL;
      end else if (skid_valid) begin
         if (deliver) begin
            main_data  <= skid_data;
            skid_valid <= 1'b0;
         end
      end else if (accept) begin
         if (!main_valid || deliver) begin
            main_valid <= 1'b1;
            main_data  <= in_data;
         end else begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
         end
      end else if (deliver) begin
         main_valid <= 1'b0;
      end
   end

`else

   // Single-register stage. A new item can be taken when the register is
   // empty, or when its current item leaves in this same cycle. That second
   // case is what gives one item per cycle under a steady out_ready. The cost
   // is a combinational path from out_ready to in_ready. Flush blocks the
   // input so that an item arriving in the flush cycle is not captured.
   assign in_ready = !flush && (!main_valid || out_ready);

   // Occupancy is simply the valid bit.
   assign occupancy = {1'b0, main_valid};

   // Single-entry storage update.
   //
   // Flush returns the register to the bubble value. Otherwise:
   //    - A new item overwrites the payload, whether or not the old one is
   //      leaving in this cycle.
   //    - A delivery with nothing behind it just drops the valid bit.
   //
   // When the register is stalled and not accepting, it holds its payload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid <= 1'b0;
         main_data  <= RESET_VAL;
      end else if (flush) begin
         main_valid <= 1'b0;
         main_data  <= RESET_VAL;
      end else if (accept) begin
         main_valid <= 1'b1;
         main_data  <= in_data;
      end else if (deliver) begin
         main_valid <= 1'b0;
      end
   end

`endif

   // Stall performance counter.
   //
   // It counts every cycle in which downstream is offered a valid payload and
   // refuses it. The count saturates at all-ones, so a long stall never wraps
   // back to a misleadingly small value. The clear input wins over the
   // increment. Flush deliberately has no effect: the counter measures
   // downstream pressure, not pipeline contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (stall_cnt_clr) begin
         stall_cnt <= '0;
      end else if (main_valid && !out_ready && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      end
   end

endmodule
